wbu: RTL and testbench
======================

// Module: wbu
// PURPOSE
//   Write-back stage: final pipeline stage between LSU and regfile write port. Registers one retiring
//   instruction per cycle (valid/ready), formats load data (byte select, sign/zero extend), drives the
//   regfile write port, forwards the pending result to IDU, and counts/flags commits for difftest.
// PARAMETERS
//   CPU_WIDTH  64  datapath width (XLEN)
//   REG_ADDRW  5   register index width
//   CNT_WIDTH  64  retired-instruction counter width
// PORTS
//   i_clk        in   1          clock; sole clock domain
//   i_rst        in   1          reset; one clock; reset is synchronous and active-high
//   i_pre_valid  in   1          LSU offers an instruction
//   o_pre_ready  out  1          WBU accepts it this cycle
//   i_pc         in   CPU_WIDTH  instruction PC
//   i_rdwen      in   1          instruction writes rd
//   i_rdid       in   REG_ADDRW  destination register
//   i_exu_res    in   CPU_WIDTH  ALU/CSR/jump-link result
//   i_ld_en      in   1          instruction is a load
//   i_ld_func    in   3          load funct3
//   i_ld_addr_lo in   3          load address bits [2:0]
//   i_ld_raw     in   CPU_WIDTH  aligned doubleword read from memory
//   i_hold       in   1          sim/debug stall: blocks retirement
//   o_wen        out  1          regfile write enable
//   o_waddr      out  REG_ADDRW  regfile write address
//   o_wdata      out  CPU_WIDTH  regfile write data
//   o_fwd_valid  out  1          pending result valid for bypass
//   o_fwd_rdid   out  REG_ADDRW  bypass register index
//   o_fwd_data   out  CPU_WIDTH  bypass data (== o_wdata)
//   o_commit     out  1          one-cycle pulse per retired instruction
//   o_commit_pc  out  CPU_WIDTH  PC of retiring instruction
//   o_instret    out  CNT_WIDTH  retired-instruction count
// BEHAVIOUR
//   - One stage register (valid_q + payload). retire = valid_q & ~i_hold.
//   - o_pre_ready = ~valid_q | retire (combinational). accept = i_pre_valid & o_pre_ready.
//   - Clock edge: accept -> load payload, valid_q<=1; else retire -> valid_q<=0; else hold.
//     Accept and retire in same cycle: back-to-back, one instruction per cycle sustained.
//   - Payload changes only on accept; held stable across i_hold cycles.
//   - Result: ld_en_q ? ld_fmt : exu_res_q. Load formatting from registered fields:
//     sh = ld_raw_q >> (8*addr_lo_q), upper bytes zero-filled; funct3 000 LB sext sh[7:0], 001 LH
//     sext sh[15:0], 010 LW sext sh[31:0], 011 LD sh, 100 LBU, 101 LHU, 110 LWU zext, 111 -> 0.
//     Misalignment not checked; result is whatever sh yields.
//   - o_wen = retire & rdwen_q & (rdid_q != 0); x0 writes suppressed. o_waddr=rdid_q, o_wdata=result.
//   - o_fwd_valid = valid_q & rdwen_q & (rdid_q != 0), independent of i_hold.
//   - o_commit = retire; o_commit_pc = pc_q. o_instret increments by 1 on each retire, wraps to 0.
//   - Latency: accept at edge N -> o_wen/o_commit high during cycle N+1 (absent hold).
//   - Reset (i_rst high at edge): valid_q=0, payload=0, instret=0 -> o_wen/o_commit/o_fwd_valid=0,
//     o_pre_ready=1. Reset mid-hold discards the pending instruction; no write, no commit.
// TESTING
//   - Reset: i_rst 2 cycles -> o_pre_ready=1, o_wen=0, o_commit=0, o_instret=0.
//   - ALU stream: 4 back-to-back valid, rd=1..4, res=0x10..0x13 -> writes 1 cycle later, one per cycle,
//     o_instret=4.
//   - Loads: raw=0x8877665544332211, lo=7 LB -> 0xFFFF_FFFF_FFFF_FF88; lo=6 LHU -> 0x8877; lo=4 LW ->
//     0xFFFF_FFFF_8877_6655; lo=0 LD -> raw; funct3=111 -> 0.
//   - x0: rdwen=1, rd=0 -> o_wen=0, o_fwd_valid=0, o_commit=1, o_instret increments.
//   - Hold: i_hold 3 cycles with valid_q=1 -> o_pre_ready=0, no write/commit, fwd stays valid;
//     release -> single write + commit.
//   - Reset during hold with pending rd=5 -> no write, o_instret=0 after reset.

Source files
------------

// File: rtl/wbu_if.sv
// rtl/wbu_if.sv - retire-side bus of the write-back stage (LSU handshake, regfile, bypass, commit)
interface wbu_if #(
  parameter int CPU_WIDTH = 64,
  parameter int REG_ADDRW = 5,
  parameter int CNT_WIDTH = 64
);
  logic                 i_pre_valid;
  logic                 o_pre_ready;
  logic [CPU_WIDTH-1:0] i_pc;
  logic                 i_rdwen;
  logic [REG_ADDRW-1:0] i_rdid;
  logic [CPU_WIDTH-1:0] i_exu_res;
  logic                 i_ld_en;
  logic [2:0]           i_ld_func;
  logic [2:0]           i_ld_addr_lo;
  logic [CPU_WIDTH-1:0] i_ld_raw;
  logic                 i_hold;
  logic                 o_wen;
  logic [REG_ADDRW-1:0] o_waddr;
  logic [CPU_WIDTH-1:0] o_wdata;
  logic                 o_fwd_valid;
  logic [REG_ADDRW-1:0] o_fwd_rdid;
  logic [CPU_WIDTH-1:0] o_fwd_data;
  logic                 o_commit;
  logic [CPU_WIDTH-1:0] o_commit_pc;
  logic [CNT_WIDTH-1:0] o_instret;

  modport master (
    output i_pre_valid, i_pc, i_rdwen, i_rdid, i_exu_res, i_ld_en, i_ld_func,
           i_ld_addr_lo, i_ld_raw, i_hold,
    input  o_pre_ready, o_wen, o_waddr, o_wdata, o_fwd_valid, o_fwd_rdid,
           o_fwd_data, o_commit, o_commit_pc, o_instret
  );

  modport slave (
    input  i_pre_valid, i_pc, i_rdwen, i_rdid, i_exu_res, i_ld_en, i_ld_func,
           i_ld_addr_lo, i_ld_raw, i_hold,
    output o_pre_ready, o_wen, o_waddr, o_wdata, o_fwd_valid, o_fwd_rdid,
           o_fwd_data, o_commit, o_commit_pc, o_instret
  );
endinterface

// File: rtl/wbu.sv
// rtl/wbu.sv - write-back stage: one-entry retire register, load formatting, regfile write, bypass, commit count
module wbu #(
  parameter int CPU_WIDTH = 64,
  parameter int REG_ADDRW = 5,
  parameter int CNT_WIDTH = 64
) (
  input  logic  i_clk,
  input  logic  i_rst,
  wbu_if.slave  bus
);
  logic                 valid_q;
  logic [CPU_WIDTH-1:0] pc_q;
  logic                 rdwen_q;
  logic [REG_ADDRW-1:0] rdid_q;
  logic [CPU_WIDTH-1:0] exu_res_q;
  logic                 ld_en_q;
  logic [2:0]           ld_func_q;
  logic [2:0]           ld_addr_lo_q;
  logic [CPU_WIDTH-1:0] ld_raw_q;
  logic [CNT_WIDTH-1:0] instret_q;

  logic                 retire;
  logic                 accept;
  logic                 rd_live;
  logic [CPU_WIDTH-1:0] sh;
  logic [CPU_WIDTH-1:0] ld_fmt;
  logic [CPU_WIDTH-1:0] result;

  // Retiring frees the slot in the same cycle, so a new instruction can enter behind it.
  assign retire          = valid_q & ~bus.i_hold;
  assign bus.o_pre_ready = ~valid_q | retire;
  assign accept          = bus.i_pre_valid & bus.o_pre_ready;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      valid_q      <= 1'b0;
      pc_q         <= '0;
      rdwen_q      <= 1'b0;
      rdid_q       <= '0;
      exu_res_q    <= '0;
      ld_en_q      <= 1'b0;
      ld_func_q    <= '0;
      ld_addr_lo_q <= '0;
      ld_raw_q     <= '0;
      instret_q    <= '0;
    end else begin
      if (accept) begin
        valid_q      <= 1'b1;
        pc_q         <= bus.i_pc;
        rdwen_q      <= bus.i_rdwen;
        rdid_q       <= bus.i_rdid;
        exu_res_q    <= bus.i_exu_res;
        ld_en_q      <= bus.i_ld_en;
        ld_func_q    <= bus.i_ld_func;
        ld_addr_lo_q <= bus.i_ld_addr_lo;
        ld_raw_q     <= bus.i_ld_raw;
      end else if (retire) begin
        valid_q <= 1'b0;
      end
      if (retire) begin
        instret_q <= instret_q + CNT_WIDTH'(1);
      end
    end
  end

  // Misaligned loads are not trapped here; bytes shifted past the top read as zero.
  assign sh = ld_raw_q >> {ld_addr_lo_q, 3'b000};

  always_comb begin
    ld_fmt = '0;
    case (ld_func_q)
      3'b000:  ld_fmt = {{(CPU_WIDTH-8){sh[7]}},   sh[7:0]};
      3'b001:  ld_fmt = {{(CPU_WIDTH-16){sh[15]}}, sh[15:0]};
      3'b010:  ld_fmt = {{(CPU_WIDTH-32){sh[31]}}, sh[31:0]};
      3'b011:  ld_fmt = sh;
      3'b100:  ld_fmt = {{(CPU_WIDTH-8){1'b0}},    sh[7:0]};
      3'b101:  ld_fmt = {{(CPU_WIDTH-16){1'b0}},   sh[15:0]};
      3'b110:  ld_fmt = {{(CPU_WIDTH-32){1'b0}},   sh[31:0]};
      default: ld_fmt = '0;
    endcase
  end

  assign result  = ld_en_q ? ld_fmt : exu_res_q;
  assign rd_live = rdwen_q & (rdid_q != '0);

  assign bus.o_wen       = retire & rd_live;
  assign bus.o_waddr     = rdid_q;
  assign bus.o_wdata     = result;
  assign bus.o_fwd_valid = valid_q & rd_live;
  assign bus.o_fwd_rdid  = rdid_q;
  assign bus.o_fwd_data  = result;
  assign bus.o_commit    = retire;
  assign bus.o_commit_pc = pc_q;
  assign bus.o_instret   = instret_q;
endmodule

// File: tb/tb_wbu.sv
// tb/tb_wbu.sv - randomized and directed bench for wbu against a queue-based retire model
module tb_wbu;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  wbu_if bus ();

  wbu dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus.slave)
  );

  typedef struct {
    logic [63:0] pc;
    logic        rdwen;
    logic [4:0]  rdid;
    logic [63:0] data;
  } ent_t;

  // Load result from the architectural definition: gather n bytes starting at lo, then extend.
  function automatic logic [63:0] ref_load(input logic [63:0] raw, input int lo, input logic [2:0] f);
    int n;
    logic [63:0] v;
    v = '0;
    if (f == 3'b111) return v;
    n = 1 << f[1:0];
    for (int k = 0; k < n; k++)
      if (lo + k < 8) v[8*k +: 8] = raw[8*(lo+k) +: 8];
    if (!f[2] && n < 8 && v[8*n-1])
      for (int b = 8 * n; b < 64; b++) v[b] = 1'b1;
    return v;
  endfunction

  task automatic drive(input logic v, input logic [63:0] pc, input logic we, input logic [4:0] rd,
                       input logic [63:0] res, input logic le, input logic [2:0] f,
                       input logic [2:0] lo, input logic [63:0] raw);
    bus.i_pre_valid  = v;
    bus.i_pc         = pc;
    bus.i_rdwen      = we;
    bus.i_rdid       = rd;
    bus.i_exu_res    = res;
    bus.i_ld_en      = le;
    bus.i_ld_func    = f;
    bus.i_ld_addr_lo = lo;
    bus.i_ld_raw     = raw;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    bus.i_pre_valid = 1'b0;
    bus.i_hold = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (bus.o_pre_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", bus.o_pre_ready); end
    checks++; if (bus.o_wen !== 1'b0) begin errors++; $display("FAIL reset_wen: got %b expected 0", bus.o_wen); end
    checks++; if (bus.o_commit !== 1'b0) begin errors++; $display("FAIL reset_commit: got %b expected 0", bus.o_commit); end
    checks++; if (bus.o_instret !== 64'd0) begin errors++; $display("FAIL reset_instret: got %0d expected 0", bus.o_instret); end
    checks++; if (bus.o_fwd_valid !== 1'b0) begin errors++; $display("FAIL reset_fwd: got %b expected 0", bus.o_fwd_valid); end
    rst = 1'b0;
    @(negedge clk);
    checks++; if (bus.o_pre_ready !== 1'b1 || bus.o_wen !== 1'b0) begin errors++; $display("FAIL post_reset_idle: got ready=%b wen=%b expected ready=1 wen=0", bus.o_pre_ready, bus.o_wen); end
  endtask

  task automatic test_alu_stream();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 64'h1000 + 64'(4*i), 1'b1, 5'(i + 1), 64'h10 + 64'(i), 1'b0, 3'b0, 3'b0, 64'h0);
      @(negedge clk);
      checks++; if (bus.o_pre_ready !== 1'b1) begin errors++; $display("FAIL alu_ready[%0d]: got %b expected 1", i, bus.o_pre_ready); end
      if (i > 0) begin
        checks++;
        if (bus.o_wen !== 1'b1 || bus.o_waddr !== 5'(i) || bus.o_wdata !== 64'h10 + 64'(i - 1)) begin
          errors++; $display("FAIL alu_write[%0d]: got wen=%b addr=%0d data=%h expected wen=1 addr=%0d data=%h",
                             i - 1, bus.o_wen, bus.o_waddr, bus.o_wdata, i, 64'h10 + 64'(i - 1));
        end
      end
      @(posedge clk); #1;
    end
    bus.i_pre_valid = 1'b0;
    @(negedge clk);
    checks++; if (bus.o_wen !== 1'b1 || bus.o_waddr !== 5'd4 || bus.o_wdata !== 64'h13) begin errors++; $display("FAIL alu_write[3]: got wen=%b addr=%0d data=%h expected wen=1 addr=4 data=13", bus.o_wen, bus.o_waddr, bus.o_wdata); end
    @(posedge clk); #1;
    @(negedge clk);
    checks++; if (bus.o_wen !== 1'b0) begin errors++; $display("FAIL alu_idle_wen: got %b expected 0", bus.o_wen); end
    checks++; if (bus.o_instret !== 64'd4) begin errors++; $display("FAIL alu_instret: got %0d expected 4", bus.o_instret); end
  endtask

  task automatic test_loads();
    logic [63:0] raw_c;
    logic [2:0]  lo_t [5];
    logic [2:0]  f_t  [5];
    logic [63:0] e_t  [5];
    raw_c = 64'h8877665544332211;
    lo_t = '{3'd7, 3'd6, 3'd4, 3'd0, 3'd0};
    f_t  = '{3'b000, 3'b101, 3'b010, 3'b011, 3'b111};
    e_t  = '{64'hFFFF_FFFF_FFFF_FF88, 64'h8877, 64'hFFFF_FFFF_8877_6655, 64'h8877665544332211, 64'h0};
    do_reset();
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 64'h2000, 1'b1, 5'd7, 64'hDEAD, 1'b1, f_t[i], lo_t[i], raw_c);
      @(posedge clk); #1;
      bus.i_pre_valid = 1'b0;
      @(negedge clk);
      checks++; if (bus.o_wen !== 1'b1 || bus.o_wdata !== e_t[i]) begin errors++; $display("FAIL load_fixed[%0d]: got wen=%b data=%h expected wen=1 data=%h", i, bus.o_wen, bus.o_wdata, e_t[i]); end
      @(posedge clk); #1;
    end
    for (int i = 0; i < 24; i++) begin
      logic [63:0] raw;
      logic [2:0]  f, lo;
      logic [63:0] exp;
      raw = {$urandom, $urandom};
      f   = 3'($urandom);
      lo  = 3'($urandom);
      exp = ref_load(raw, int'(lo), f);
      drive(1'b1, 64'h3000, 1'b1, 5'd9, 64'hBEEF, 1'b1, f, lo, raw);
      @(posedge clk); #1;
      bus.i_pre_valid = 1'b0;
      @(negedge clk);
      checks++; if (bus.o_wdata !== exp || bus.o_fwd_data !== exp) begin errors++; $display("FAIL load_rand[%0d]: f=%0d lo=%0d raw=%h got wdata=%h fwd=%h expected %h", i, f, lo, raw, bus.o_wdata, bus.o_fwd_data, exp); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_x0();
    do_reset();
    drive(1'b1, 64'h4000, 1'b1, 5'd0, 64'h55, 1'b0, 3'b0, 3'b0, 64'h0);
    @(posedge clk); #1;
    bus.i_pre_valid = 1'b0;
    @(negedge clk);
    checks++; if (bus.o_wen !== 1'b0) begin errors++; $display("FAIL x0_wen: got %b expected 0", bus.o_wen); end
    checks++; if (bus.o_fwd_valid !== 1'b0) begin errors++; $display("FAIL x0_fwd: got %b expected 0", bus.o_fwd_valid); end
    checks++; if (bus.o_commit !== 1'b1 || bus.o_commit_pc !== 64'h4000) begin errors++; $display("FAIL x0_commit: got commit=%b pc=%h expected commit=1 pc=4000", bus.o_commit, bus.o_commit_pc); end
    @(posedge clk); #1;
    @(negedge clk);
    checks++; if (bus.o_instret !== 64'd1) begin errors++; $display("FAIL x0_instret: got %0d expected 1", bus.o_instret); end
  endtask

  task automatic test_hold();
    do_reset();
    drive(1'b1, 64'h5000, 1'b1, 5'd9, 64'hAAAA, 1'b0, 3'b0, 3'b0, 64'h0);
    @(posedge clk); #1;
    drive(1'b1, 64'h5004, 1'b1, 5'd10, 64'hBBBB, 1'b0, 3'b0, 3'b0, 64'h0);
    bus.i_hold = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++; if (bus.o_pre_ready !== 1'b0) begin errors++; $display("FAIL hold_ready[%0d]: got %b expected 0", c, bus.o_pre_ready); end
      checks++; if (bus.o_wen !== 1'b0 || bus.o_commit !== 1'b0) begin errors++; $display("FAIL hold_quiet[%0d]: got wen=%b commit=%b expected 0 0", c, bus.o_wen, bus.o_commit); end
      checks++; if (bus.o_fwd_valid !== 1'b1 || bus.o_fwd_rdid !== 5'd9 || bus.o_fwd_data !== 64'hAAAA) begin errors++; $display("FAIL hold_fwd[%0d]: got v=%b rd=%0d d=%h expected v=1 rd=9 d=aaaa", c, bus.o_fwd_valid, bus.o_fwd_rdid, bus.o_fwd_data); end
      @(posedge clk); #1;
    end
    bus.i_hold = 1'b0;
    @(negedge clk);
    checks++; if (bus.o_wen !== 1'b1 || bus.o_waddr !== 5'd9 || bus.o_commit !== 1'b1 || bus.o_commit_pc !== 64'h5000) begin errors++; $display("FAIL hold_release: got wen=%b addr=%0d commit=%b pc=%h expected 1 9 1 5000", bus.o_wen, bus.o_waddr, bus.o_commit, bus.o_commit_pc); end
    checks++; if (bus.o_pre_ready !== 1'b1) begin errors++; $display("FAIL hold_release_ready: got %b expected 1", bus.o_pre_ready); end
    @(posedge clk); #1;
    bus.i_pre_valid = 1'b0;
    @(negedge clk);
    checks++; if (bus.o_wen !== 1'b1 || bus.o_waddr !== 5'd10 || bus.o_wdata !== 64'hBBBB) begin errors++; $display("FAIL hold_next: got wen=%b addr=%0d data=%h expected 1 10 bbbb", bus.o_wen, bus.o_waddr, bus.o_wdata); end
    @(posedge clk); #1;
    @(negedge clk);
    checks++; if (bus.o_instret !== 64'd2 || bus.o_wen !== 1'b0) begin errors++; $display("FAIL hold_instret: got cnt=%0d wen=%b expected 2 0", bus.o_instret, bus.o_wen); end
  endtask

  task automatic test_reset_hold();
    do_reset();
    drive(1'b1, 64'h6000, 1'b1, 5'd5, 64'h77, 1'b0, 3'b0, 3'b0, 64'h0);
    @(posedge clk); #1;
    bus.i_pre_valid = 1'b0;
    bus.i_hold = 1'b1;
    @(negedge clk);
    checks++; if (bus.o_fwd_valid !== 1'b1 || bus.o_wen !== 1'b0) begin errors++; $display("FAIL rsthold_pending: got fwd=%b wen=%b expected 1 0", bus.o_fwd_valid, bus.o_wen); end
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    bus.i_hold = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      checks++; if (bus.o_wen !== 1'b0 || bus.o_commit !== 1'b0 || bus.o_fwd_valid !== 1'b0) begin errors++; $display("FAIL rsthold_dropped[%0d]: got wen=%b commit=%b fwd=%b expected 0 0 0", c, bus.o_wen, bus.o_commit, bus.o_fwd_valid); end
      checks++; if (bus.o_instret !== 64'd0 || bus.o_pre_ready !== 1'b1) begin errors++; $display("FAIL rsthold_state[%0d]: got cnt=%0d ready=%b expected 0 1", c, bus.o_instret, bus.o_pre_ready); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_random();
    ent_t        q[$];
    logic [63:0] exp_ret;
    do_reset();
    exp_ret = '0;
    for (int c = 0; c < 400; c++) begin
      logic        v, h, le, we, occ, com, e_wen, e_fwd, e_ready;
      logic [2:0]  f, lo;
      logic [4:0]  rd;
      logic [63:0] pc, res, raw;
      ent_t        e;
      @(negedge clk);
      v   = ($urandom_range(0, 9) < 7);
      h   = ($urandom_range(0, 3) == 0);
      le  = 1'($urandom);
      we  = ($urandom_range(0, 3) != 0);
      rd  = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
      f   = 3'($urandom);
      lo  = 3'($urandom);
      pc  = {32'h0, $urandom} & ~64'h3;
      res = {$urandom, $urandom};
      raw = {$urandom, $urandom};
      drive(v, pc, we, rd, res, le, f, lo, raw);
      bus.i_hold = h;
      #1;
      occ     = (q.size() != 0);
      com     = occ && !h;
      e_ready = !occ || !h;
      e_fwd   = occ && q[0].rdwen && (q[0].rdid != 5'd0);
      e_wen   = com && e_fwd;
      checks++; if (bus.o_pre_ready !== e_ready) begin errors++; $display("FAIL rnd_ready[%0d]: got %b expected %b", c, bus.o_pre_ready, e_ready); end
      checks++; if (bus.o_commit !== com || bus.o_wen !== e_wen || bus.o_fwd_valid !== e_fwd) begin errors++; $display("FAIL rnd_ctrl[%0d]: got commit=%b wen=%b fwd=%b expected %b %b %b", c, bus.o_commit, bus.o_wen, bus.o_fwd_valid, com, e_wen, e_fwd); end
      checks++; if (bus.o_instret !== exp_ret) begin errors++; $display("FAIL rnd_instret[%0d]: got %0d expected %0d", c, bus.o_instret, exp_ret); end
      if (com) begin
        checks++; if (bus.o_commit_pc !== q[0].pc) begin errors++; $display("FAIL rnd_pc[%0d]: got %h expected %h", c, bus.o_commit_pc, q[0].pc); end
      end
      if (e_fwd) begin
        checks++; if (bus.o_waddr !== q[0].rdid || bus.o_wdata !== q[0].data || bus.o_fwd_rdid !== q[0].rdid || bus.o_fwd_data !== q[0].data) begin
          errors++; $display("FAIL rnd_data[%0d]: got addr=%0d data=%h fwd_rd=%0d fwd_d=%h expected addr=%0d data=%h", c, bus.o_waddr, bus.o_wdata, bus.o_fwd_rdid, bus.o_fwd_data, q[0].rdid, q[0].data);
        end
      end
      if (com) begin
        void'(q.pop_front());
        exp_ret++;
      end
      if (v && e_ready) begin
        e.pc    = pc;
        e.rdwen = we;
        e.rdid  = rd;
        e.data  = le ? ref_load(raw, int'(lo), f) : res;
        q.push_back(e);
      end
    end
    bus.i_pre_valid = 1'b0;
    bus.i_hold = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1);
  end

  initial begin
    bus.i_hold = 1'b0;
    drive(1'b0, 64'h0, 1'b0, 5'd0, 64'h0, 1'b0, 3'b0, 3'b0, 64'h0);
    test_reset();
    test_alu_stream();
    test_loads();
    test_x0();
    test_hold();
    test_reset_hold();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
